aes_round_ctrl: RTL and testbench
=================================

// Module: aes_round_ctrl
// PURPOSE
//  Iterative AES encryption round sequencer. Accepts one 128-bit block, applies the initial
//  AddRoundKey, then drives the external combinational round datapath once per round:
//  SubBytes -> ShiftRows -> MixColumns (bypassed in the last round) -> AddRoundKey.
//  Fetches round keys from the key schedule over a req/valid handshake. Owns the state register.
//  Sits between the block-level valid/ready interface and the round datapath.
// PARAMETERS
//  NR  10  number of rounds; legal 10/12/14 (AES-128/192/256); any other value is an elaboration error
// PORTS
//  clk           in   1    clock, rising edge
//  rst_n         in   1    asynchronous reset, active low
//  in_valid      in   1    input block valid
//  in_ready      out  1    controller can accept a block
//  in_block      in   128  plaintext; byte 0 at [127:120], column-major
//  rk_req        out  1    round key request
//  rk_idx        out  4    requested round key index, 0..NR
//  rk_valid      in   1    round key for rk_idx valid this cycle
//  rk            in   128  round key
//  rnd_state     out  128  current state, to round datapath
//  rnd_last      out  1    datapath must bypass MixColumns
//  rnd_result    in   128  combinational datapath result for rnd_state/rk/rnd_last
//  out_valid     out  1    ciphertext valid
//  out_ready     in   1    downstream accepts ciphertext
//  out_block     out  128  ciphertext (= state register)
//  busy          out  1    high in any state except IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0): FSM=IDLE, round counter=0, state reg=0; all outputs 0 except in_ready=1.
//  - FSM states: IDLE, KEY0, ROUND, DONE.
//  - IDLE: in_ready=1. in_valid&in_ready -> capture in_block into pending reg, go KEY0, counter=0.
//  - KEY0: rk_req=1, rk_idx=0. On rk_valid: state <= pending ^ rk; counter<=1; go ROUND.
//  - ROUND: rk_req=1, rk_idx=counter, rnd_last=(counter==NR). On rk_valid: state <= rnd_result;
//    if counter==NR go DONE, else counter++. Without rk_valid: hold everything (stall, any length).
//  - DONE: out_valid=1, out_block stable until out_valid&out_ready, then go IDLE, counter=0.
//  - in_ready=0 outside IDLE; in_valid there is ignored (no capture, no error).
//  - rk sampled only when rk_req&rk_valid; rk_valid while rk_req=0 has no effect.
//  - rk_req/rk_idx/rnd_last are Moore outputs of FSM+counter; rk_idx held constant during a stall.
//  - rnd_state = state reg continuously; rnd_last=0 outside ROUND.
//  - Latency, rk_valid tied 1: out_valid rises NR+1 edges after accept edge (11 for NR=10).
//    Min per-block period NR+3 cycles (accept, KEY0, NR rounds, DONE handshake).
//  - Counter 4 bits; never exceeds NR; no wrap.
//  - Reset mid-operation aborts the block immediately; no partial output emitted.
// TESTING
//  1 FIPS-197 C.1: key 000102..0f, pt 00112233445566778899aabbccddeeff, rk_valid=1
//    -> out_block 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 11 edges after accept.
//  2 Same vector, rk_valid low 3 cycles at each of idx 0, 5 and 10
//    -> same ciphertext, latency 20, rk_idx stable during stalls.
//  3 out_ready low 5 cycles in DONE -> out_valid/out_block stable; in_ready=0 until handshake, then 1.
//  4 in_valid pulsed with different block during ROUND
//    -> ignored; ciphertext matches first block; next block accepted only in IDLE.
//  5 rst_n low at counter=6 -> all outputs 0, in_ready=1 asynchronously;
//    new C.1 block after release -> correct ciphertext.
//  6 rk_valid=1 while IDLE/DONE, and NR=14 with FIPS-197 C.3 vector
//    -> no state change / ciphertext 8ea2b7ca516745bfeafc49904b496089.

Source files
------------

// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: block, key-schedule and round-datapath signals of the AES round sequencer
interface aes_round_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic         rk_req;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic [127:0] rk;
  logic [127:0] rnd_state;
  logic         rnd_last;
  logic [127:0] rnd_result;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic         busy;
  modport master (
    input  in_valid, in_block, rk_valid, rk, rnd_result, out_ready,
    output in_ready, rk_req, rk_idx, rnd_state, rnd_last, out_valid, out_block, busy
  );
  modport slave (
    output in_valid, in_block, rk_valid, rk, rnd_result, out_ready,
    input  in_ready, rk_req, rk_idx, rnd_state, rnd_last, out_valid, out_block, busy
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES encryption round sequencer driving an external round datapath
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input logic             clk,
  input logic             rst_n,
  aes_round_ctrl_if.master bus
);
  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_nr_check
    $error("aes_round_ctrl: NR must be 10, 12 or 14");
  end
  localparam logic [3:0] LAST = 4'(NR);
  typedef enum logic [1:0] {IDLE, KEY0, ROUND, DONE} state_t;
  state_t       st, nx;
  logic [3:0]   cnt;
  logic [127:0] pend, sreg;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= nx;
  always_comb begin
    nx            = st;
    bus.in_ready  = 1'b0;
    bus.rk_req    = 1'b0;
    bus.rk_idx    = 4'd0;
    bus.rnd_last  = 1'b0;
    bus.out_valid = 1'b0;
    case (st)
      IDLE: begin
        bus.in_ready = 1'b1;
        nx = bus.in_valid ? KEY0 : IDLE;
      end
      KEY0: begin
        bus.rk_req = 1'b1;
        nx = bus.rk_valid ? ROUND : KEY0;
      end
      ROUND: begin
        bus.rk_req   = 1'b1;
        bus.rk_idx   = cnt;
        bus.rnd_last = cnt == LAST;
        nx = (bus.rk_valid && cnt == LAST) ? DONE : ROUND;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        nx = bus.out_ready ? IDLE : DONE;
      end
      default: nx = IDLE;
    endcase
  end
  // The key is consumed only while requested, so rk_valid in IDLE/DONE is inert.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= 4'd0;
      pend <= '0;
      sreg <= '0;
    end else if (st == IDLE && bus.in_valid) begin
      pend <= bus.in_block;
      cnt  <= 4'd0;
    end else if (st == KEY0 && bus.rk_valid) begin
      sreg <= pend ^ bus.rk;
      cnt  <= 4'd1;
    end else if (st == ROUND && bus.rk_valid) begin
      sreg <= bus.rnd_result;
      cnt  <= cnt == LAST ? cnt : cnt + 4'd1;
    end else if (st == DONE && bus.out_ready) begin
      cnt  <= 4'd0;
    end
  assign bus.busy      = st != IDLE;
  assign bus.rnd_state = sreg;
  assign bus.out_block = sreg;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: scoreboard bench for aes_round_ctrl (NR=10 and NR=14) against an AES model
module tb_aes_round_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_round_ctrl_if if10();
  aes_round_ctrl_if if14();
  aes_round_ctrl #(.NR(10)) u10 (.clk(clk), .rst_n(rst_n), .bus(if10));
  aes_round_ctrl #(.NR(14)) u14 (.clk(clk), .rst_n(rst_n), .bus(if14));

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc10 = 0;
  int acc14 = 0;
  logic [7:0]    sb [256];
  logic [2047:0] ks10, ks14;
  logic [127:0]  q10[$], q14[$];
  int            l10[$], l14[$];
  int rkm = 0;
  int orm = 0;

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] v = 8'h00;
    for (int y = 1; y < 256; y++) if (gm(x, 8'(y)) == 8'h01) v = 8'(y);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [2047:0] expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc = 8'h01;
    logic [2047:0] o = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) o[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return o;
  endfunction

  function automatic logic [127:0] rnd(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sb[s[127-8*i -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r+4*c] = b[r+4*((c+r)%4)];
    if (!last)
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
        t[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
      end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ k;
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] pt, input logic [2047:0] ks, input int nr);
    logic [127:0] s = pt ^ ks[127:0];
    for (int r = 1; r <= nr; r++) s = rnd(s, ks[r*128 +: 128], r == nr);
    return s;
  endfunction

  // Environment: round datapath and key schedule ROM
  always_comb if10.rnd_result = rnd(if10.rnd_state, if10.rk, if10.rnd_last);
  always_comb if14.rnd_result = rnd(if14.rnd_state, if14.rk, if14.rnd_last);
  assign if10.rk = ks10[{if10.rk_idx, 7'd0} +: 128];
  assign if14.rk = ks14[{if14.rk_idx, 7'd0} +: 128];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (if10.in_valid && if10.in_ready) acc10 <= cyc + 1;
    if (if14.in_valid && if14.in_ready) acc14 <= cyc + 1;
  end

  logic         pv10 = 1'b0, hold = 1'b0, hs = 1'b0, pv14 = 1'b0;
  logic [127:0] hb;
  int sc = 0, sidx = 0, hc = 0;

  always @(negedge clk) begin
    if (rkm == 2 && if10.rk_req && (if10.rk_idx == 0 || if10.rk_idx == 5 || if10.rk_idx == 10) && sc < 3) begin
      if (sc > 0) chk("stall_rk_idx", 128'(if10.rk_idx), 128'(sidx));
      sidx = int'(if10.rk_idx);
      sc++;
      if10.rk_valid = 1'b0;
    end else begin
      if10.rk_valid = rkm == 1 ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (if10.rk_valid && if10.rk_req) sc = 0;
    end
    if (orm == 2 && if10.out_valid && hc < 5) begin
      if10.out_ready = 1'b0;
      hc++;
    end else begin
      if10.out_ready = orm == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
      if (if10.out_valid && if10.out_ready) hc = 0;
    end
    if14.rk_valid  = 1'b1;
    if14.out_ready = 1'b1;
    if (!rst_n) begin
      pv10 = 1'b0; hold = 1'b0; hs = 1'b0; pv14 = 1'b0;
    end else begin
      if (hs) chk("in_ready_after_done", 128'(if10.in_ready), 128'd1);
      if (hold) begin
        chk("done_hold_block", if10.out_block, hb);
        chk("done_hold_valid", 128'(if10.out_valid), 128'd1);
        chk("done_in_ready", 128'(if10.in_ready), 128'd0);
      end
      hs = 1'b0;
      hold = 1'b0;
      if (if10.rnd_last) chk("rnd_last_idx", 128'(if10.rk_idx), 128'd10);
      if (if10.out_valid && !pv10 && l10.size() > 0 && l10[0] >= 0)
        chk("latency10", 128'(cyc - acc10), 128'(l10[0]));
      if (if10.out_valid && if10.out_ready) begin
        if (q10.size() == 0) chk("unexpected_out10", 128'd1, 128'd0);
        else begin
          chk("cipher10", if10.out_block, q10.pop_front());
          void'(l10.pop_front());
        end
        hs = 1'b1;
      end else if (if10.out_valid) begin
        hold = 1'b1;
        hb = if10.out_block;
      end
      pv10 = if10.out_valid;
      if (if14.out_valid && !pv14 && l14.size() > 0 && l14[0] >= 0)
        chk("latency14", 128'(cyc - acc14), 128'(l14[0]));
      if (if14.out_valid) begin
        if (q14.size() == 0) chk("unexpected_out14", 128'd1, 128'd0);
        else begin
          chk("cipher14", if14.out_block, q14.pop_front());
          void'(l14.pop_front());
        end
      end
      pv14 = if14.out_valid;
    end
  end

  task automatic send10(input logic [127:0] b, input logic [127:0] e, input int lat);
    int n = 0;
    @(negedge clk);
    if10.in_valid = 1'b1;
    if10.in_block = b;
    while (!if10.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("accept_timeout10", 128'd1, 128'd0);
    else begin
      q10.push_back(e);
      l10.push_back(lat);
    end
    @(negedge clk);
    if10.in_valid = 1'b0;
  endtask

  task automatic send14(input logic [127:0] b, input logic [127:0] e, input int lat);
    int n = 0;
    @(negedge clk);
    if14.in_valid = 1'b1;
    if14.in_block = b;
    while (!if14.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("accept_timeout14", 128'd1, 128'd0);
    else begin
      q14.push_back(e);
      l14.push_back(lat);
    end
    @(negedge clk);
    if14.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q10.size() != 0 || q14.size() != 0 || !if10.in_ready || !if14.in_ready) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) chk("idle_timeout", 128'd1, 128'd0);
  endtask

  task automatic wait_idx(input int v);
    int n = 0;
    while (!(if10.rk_req && int'(if10.rk_idx) == v) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("rk_idx_timeout", 128'd1, 128'd0);
  endtask

  initial begin
    logic [127:0] b, s;
    logic [255:0] k;
    if10.in_valid = 1'b0; if10.in_block = '0;
    if14.in_valid = 1'b0; if14.in_block = '0;
    for (int x = 0; x < 256; x++) sb[x] = sbox_calc(8'(x));
    ks10 = expand(K1, 4, 10);
    ks14 = expand(K3, 8, 14);
    chk("model_c1", enc(PT, ks10, 10), CT1);
    chk("model_c3", enc(PT, ks14, 14), CT3);
    #1;
    chk("rst_in_ready", 128'(if10.in_ready), 128'd1);
    chk("rst_outs", {if10.rk_req, if10.rk_idx, if10.rnd_last, if10.out_valid, if10.busy}, 128'd0);
    chk("rst_state", if10.rnd_state, 128'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send10(PT, CT1, 11);
    wait_idle();
    rkm = 2;
    send10(PT, CT1, 20);
    wait_idle();
    rkm = 0;
    orm = 2;
    send10(PT, CT1, 11);
    wait_idle();
    orm = 0;
    b = {$urandom, $urandom, $urandom, $urandom};
    send10(PT, CT1, 11);
    wait_idx(3);
    if10.in_valid = 1'b1;
    if10.in_block = b;
    repeat (2) begin
      @(negedge clk);
      chk("in_ready_busy", 128'(if10.in_ready), 128'd0);
    end
    if10.in_valid = 1'b0;
    wait_idle();
    send10(b, enc(b, ks10, 10), 11);
    wait_idle();
    send10(PT, CT1, 11);
    wait_idx(6);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 128'(if10.in_ready), 128'd1);
    chk("arst_outs", {if10.rk_req, if10.rk_idx, if10.rnd_last, if10.out_valid, if10.busy}, 128'd0);
    chk("arst_state", if10.rnd_state, 128'd0);
    chk("arst_block", if10.out_block, 128'd0);
    q10.delete();
    l10.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send10(PT, CT1, 11);
    wait_idle();
    s = if10.rnd_state;
    repeat (4) @(negedge clk);
    chk("idle_rk_valid_state", if10.rnd_state, s);
    chk("idle_rk_valid_outs", {if10.busy, if10.out_valid, if10.rk_req}, 128'd0);
    send14(PT, CT3, 15);
    wait_idle();
    repeat (4) begin
      b = {$urandom, $urandom, $urandom, $urandom};
      send10(b, enc(b, ks10, 10), 11);
    end
    wait_idle();
    rkm = 1;
    orm = 1;
    for (int i = 0; i < 12; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom, 128'h0};
      ks10 = expand(k, 4, 10);
      b = {$urandom, $urandom, $urandom, $urandom};
      send10(b, enc(b, ks10, 10), -1);
      wait_idle();
    end
    for (int i = 0; i < 3; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ks14 = expand(k, 8, 14);
      b = {$urandom, $urandom, $urandom, $urandom};
      send14(b, enc(b, ks14, 14), 15);
      wait_idle();
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
